// File: rtl/pixel_capture.sv
`default_nettype none
// ============================================================================
// Module   : pixel_capture
// Function : Captures one camera frame (VSYNC/HREF/DATA) into SRAM port s0
//            with crop window, power-of-2 decimation and sample packing.
//            Optional CRC-16-CCITT output when CAPTURE_CRC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_capture #(
    parameter int          DATA_W    = 8,
    parameter int          WORD_W    = 32,
    parameter int          ADDR_W    = 18,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_kick,
    output logic              fetch_done,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [DATA_W-1:0] DATA,
    input  logic [11:0]       win_x0,
    input  logic [11:0]       win_x1,
    input  logic [9:0]        win_y0,
    input  logic [9:0]        win_y1,
    input  logic [1:0]        dec_log2,
    output logic              s0_WE,
    output logic [ADDR_W-1:0] s0_Addr,
    output logic [WORD_W-1:0] s0_WD,
    output logic [ADDR_W-1:0] last_addr,
`ifdef CAPTURE_CRC_EN
    output logic [15:0]       crc,
`endif
    output logic              overflow
);

    localparam int BPW    = WORD_W / DATA_W;
    localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_SYNC   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state;
    logic              vsync_q, href_q;
    logic [11:0]       x_cnt, wx0, wx1;
    logic [9:0]        y_cnt, wy0, wy1;
    logic [1:0]        dec;
    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] pack;
    logic [ADDR_W-1:0] ptr;
    logic              full;

    logic              vs_rise, vs_fall, href_fall;
    logic [11:0]       x_mask;
    logic [9:0]        y_mask;
    logic              keep, word_full, flush_wr, issue;
    logic [WORD_W-1:0] merged, wr_word;

    assign vs_rise   = VSYNC & ~vsync_q;
    assign vs_fall   = ~VSYNC & vsync_q;
    assign href_fall = ~HREF & href_q;
    assign x_mask    = (12'd1 << dec) - 12'd1;
    assign y_mask    = (10'd1 << dec) - 10'd1;

    // An empty window (x0>x1 or y0>y1) fails the range test by construction.
    assign keep = (state == S_ACTIVE) && HREF
               && (x_cnt >= wx0) && (x_cnt <= wx1)
               && (y_cnt >= wy0) && (y_cnt <= wy1)
               && ((x_cnt & x_mask) == 12'd0) && ((y_cnt & y_mask) == 10'd0);

    always_comb begin
        merged = pack;
        merged[lane*DATA_W +: DATA_W] = DATA;
    end

    assign word_full = keep && (lane == LANE_W'(BPW - 1));
    assign flush_wr  = (state == S_FLUSH) && (lane != '0);
    assign issue     = word_full | flush_wr;
    assign wr_word   = flush_wr ? pack : merged;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            wx0        <= '0;
            wx1        <= '0;
            wy0        <= '0;
            wy1        <= '0;
            dec        <= '0;
            lane       <= '0;
            pack       <= '0;
            ptr        <= BASE;
            full       <= 1'b0;
            fetch_done <= 1'b0;
            s0_WE      <= 1'b1;
            s0_Addr    <= BASE;
            s0_WD      <= '0;
            last_addr  <= BASE;
            overflow   <= 1'b0;
        end else begin
            vsync_q    <= VSYNC;
            href_q     <= HREF;
            fetch_done <= 1'b0;
            s0_WE      <= 1'b1;
            if (!issue) s0_Addr <= ptr;

            case (state)
                S_IDLE: begin
                    if (fetch_kick) begin
                        wx0       <= win_x0;
                        wx1       <= win_x1;
                        wy0       <= win_y0;
                        wy1       <= win_y1;
                        dec       <= dec_log2;
                        overflow  <= 1'b0;
                        full      <= 1'b0;
                        ptr       <= BASE;
                        s0_Addr   <= BASE;
                        last_addr <= BASE;
                        lane      <= '0;
                        pack      <= '0;
                        x_cnt     <= '0;
                        y_cnt     <= '0;
                        state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (vs_rise) state <= S_SYNC;
                end
                S_SYNC: begin
                    x_cnt <= '0;
                    y_cnt <= '0;
                    if (vs_fall) state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (HREF) begin
                        if (x_cnt != '1) x_cnt <= x_cnt + 12'd1;
                    end else if (href_fall) begin
                        x_cnt <= '0;
                        if (y_cnt != '1) y_cnt <= y_cnt + 10'd1;
                    end
                    if (keep) begin
                        if (word_full) begin
                            lane <= '0;
                            pack <= '0;
                        end else begin
                            lane <= lane + LANE_W'(1);
                            pack <= merged;
                        end
                    end
                    if (vs_rise) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    lane       <= '0;
                    pack       <= '0;
                    fetch_done <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // Once the top address is written the pointer parks; later words are dropped.
            if (issue) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    s0_WE     <= 1'b0;
                    s0_WD     <= wr_word;
                    s0_Addr   <= ptr;
                    last_addr <= ptr;
                    if (ptr == ADDR_MAX) full <= 1'b1;
                    else                 ptr  <= ptr + ADDR_W'(1);
                end
            end
        end
    end

`ifdef CAPTURE_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c_in,
                                             input logic [DATA_W-1:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          crc <= 16'hFFFF;
        else if (state == S_IDLE && fetch_kick) crc <= 16'hFFFF;
        else if (keep)                          crc <= crc_step(crc, DATA);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_capture
// Function : Directed bench for pixel_capture (two instances: base 0 and
//            base 2^18-2); CRC check enabled when CAPTURE_CRC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pixel_capture;

    logic        clk = 1'b0;
    logic        reset_n, fetch_kick, VSYNC, HREF;
    logic [7:0]  DATA;
    logic [11:0] win_x0, win_x1;
    logic [9:0]  win_y0, win_y1;
    logic [1:0]  dec_log2;

    logic        done0, we0, ov0, done1, we1, ov1;
    logic [17:0] addr0, la0, addr1, la1;
    logic [31:0] wd0, wd1;
`ifdef CAPTURE_CRC_EN
    logic [15:0] crc0, crc1;
`endif

    always #5 clk = ~clk;

    pixel_capture #(.DATA_W(8), .WORD_W(32), .ADDR_W(18), .BASE_ADDR(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .fetch_kick(fetch_kick), .fetch_done(done0),
        .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA),
        .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
        .dec_log2(dec_log2), .s0_WE(we0), .s0_Addr(addr0), .s0_WD(wd0),
        .last_addr(la0),
`ifdef CAPTURE_CRC_EN
        .crc(crc0),
`endif
        .overflow(ov0));

    pixel_capture #(.DATA_W(8), .WORD_W(32), .ADDR_W(18), .BASE_ADDR(32'h3FFFE)) dut1 (
        .clk(clk), .reset_n(reset_n), .fetch_kick(fetch_kick), .fetch_done(done1),
        .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA),
        .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
        .dec_log2(dec_log2), .s0_WE(we1), .s0_Addr(addr1), .s0_WD(wd1),
        .last_addr(la1),
`ifdef CAPTURE_CRC_EN
        .crc(crc1),
`endif
        .overflow(ov1));

    logic [31:0] qa0[$], qd0[$], qa1[$], qd1[$], ea[$], ed[$];
    int          dn0, dn1;
    int          total = 0;
    int          bad   = 0;

    always @(negedge clk) begin
        if (!we0) begin qa0.push_back(32'(addr0)); qd0.push_back(wd0); end
        if (!we1) begin qa1.push_back(32'(addr1)); qd1.push_back(wd1); end
        if (done0) dn0++;
        if (done1) dn1++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
        dn0 = 0; dn1 = 0;
    endtask

    task automatic ew(input logic [31:0] a, input logic [31:0] d);
        ea.push_back(a); ed.push_back(d);
    endtask

    task automatic cmp_writes(input string tag, input int sel);
        int n;
        n = (sel != 0) ? qa1.size() : qa0.size();
        chk({tag, "_count"}, n, ea.size());
        for (int i = 0; i < ea.size() && i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), (sel != 0) ? qa1[i] : qa0[i], ea[i]);
            chk($sformatf("%s_data%0d", tag, i), (sel != 0) ? qd1[i] : qd0[i], ed[i]);
        end
        ea.delete(); ed.delete();
    endtask

    task automatic set_win(input int x0, input int x1, input int y0, input int y1, input int d);
        win_x0 = 12'(x0); win_x1 = 12'(x1);
        win_y0 = 10'(y0); win_y1 = 10'(y1);
        dec_log2 = 2'(d);
    endtask

    // Frame sample value is base + line*ns + sample.
    task automatic run_frame(input int nl, input int ns, input int base,
                             input bit kick_mid, input bit exp_done);
        clear_mon();
        @(negedge clk) fetch_kick = 1'b1;
        @(negedge clk) fetch_kick = 1'b0;
        if (exp_done) begin
            chk("kick_clears_ov0", ov0, 0);
            chk("kick_clears_ov1", ov1, 0);
        end
        repeat (2) @(negedge clk);
        VSYNC = 1'b1;
        repeat (3) @(negedge clk);
        VSYNC = 1'b0;
        repeat (2) @(negedge clk);
        for (int l = 0; l < nl; l++) begin
            for (int x = 0; x < ns; x++) begin
                @(negedge clk);
                HREF = 1'b1;
                DATA = 8'(base + l * ns + x);
                fetch_kick = (kick_mid && l == 1 && x == 0);
            end
            @(negedge clk);
            HREF = 1'b0;
            fetch_kick = 1'b0;
            repeat (2) @(negedge clk);
        end
        VSYNC = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (dn0 != 0) break;
        end
        if (exp_done) chk("done_seen", dn0 != 0, 1);
        repeat (3) @(negedge clk);
        VSYNC = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; fetch_kick = 1'b0; VSYNC = 1'b0; HREF = 1'b0; DATA = '0;
        set_win(0, 7, 0, 3, 0);
        clear_mon();
        repeat (3) @(negedge clk);
        chk("rst_we",    we0,   1);
        chk("rst_addr0", addr0, 0);
        chk("rst_addr1", addr1, 32'h3FFFE);
        chk("rst_wd",    wd0,   0);
        chk("rst_last1", la1,   32'h3FFFE);
        chk("rst_done",  done0, 0);
        chk("rst_ov",    ov0,   0);
`ifdef CAPTURE_CRC_EN
        chk("rst_crc",   crc0,  32'hFFFF);
`endif
        @(negedge clk) reset_n = 1'b1;

        // Full window, no decimation.
        set_win(0, 7, 0, 3, 0);
        run_frame(4, 8, 0, 0, 1);
        ew(0, 32'h03020100); ew(1, 32'h07060504); ew(2, 32'h0B0A0908); ew(3, 32'h0F0E0D0C);
        ew(4, 32'h13121110); ew(5, 32'h17161514); ew(6, 32'h1B1A1918); ew(7, 32'h1F1E1D1C);
        cmp_writes("t1", 0);
        chk("t1_last", la0, 7);
        chk("t1_done", dn0, 1);

        // Empty window: no writes, last_addr back to base, done still pulses.
        set_win(5, 2, 0, 3, 0);
        run_frame(4, 8, 0, 0, 1);
        cmp_writes("empty", 0);
        chk("empty_last", la0, 0);
        chk("empty_done", dn0, 1);

        set_win(2, 5, 1, 2, 0);
        run_frame(4, 8, 0, 0, 1);
        ew(0, 32'h0D0C0B0A); ew(1, 32'h15141312);
        cmp_writes("t2", 0);
        chk("t2_last", la0, 1);

        set_win(0, 7, 0, 3, 1);
        run_frame(4, 8, 0, 0, 1);
        ew(0, 32'h06040200); ew(1, 32'h16141210);
        cmp_writes("t3", 0);

        set_win(0, 4, 0, 0, 0);
        run_frame(4, 8, 0, 0, 1);
        ew(0, 32'h03020100); ew(1, 32'h00000004);
        cmp_writes("t4a", 0);
        chk("t4a_last", la0, 1);

        set_win(3, 3, 2, 2, 0);
        run_frame(4, 8, 0, 0, 1);
        ew(0, 32'h00000013);
        cmp_writes("t4b", 0);
        chk("t4b_last", la0, 0);

        // 12 samples: instance 1 runs out of address space after two words.
        set_win(0, 3, 0, 2, 0);
        run_frame(4, 8, 0, 0, 1);
        ew(32'h3FFFE, 32'h03020100); ew(32'h3FFFF, 32'h0B0A0908);
        cmp_writes("t5", 1);
        chk("t5_ov1",   ov1, 1);
        chk("t5_last1", la1, 32'h3FFFF);
        chk("t5_done1", dn1, 1);
        ew(0, 32'h03020100); ew(1, 32'h0B0A0908); ew(2, 32'h13121110);
        cmp_writes("t5_base0", 0);
        chk("t5_ov0", ov0, 0);

        // ASCII "123456789"; next kick also clears instance 1 overflow.
        set_win(0, 8, 0, 0, 0);
        run_frame(1, 9, 32'h31, 0, 1);
        ew(0, 32'h34333231); ew(1, 32'h38373635); ew(2, 32'h00000039);
        cmp_writes("crcfrm", 0);
`ifdef CAPTURE_CRC_EN
        chk("crc_value", crc0, 32'h29B1);
`endif

        // Kick during ACTIVE must not disturb the frame.
        set_win(0, 7, 0, 3, 0);
        run_frame(4, 8, 0, 1, 1);
        ew(0, 32'h03020100); ew(1, 32'h07060504); ew(2, 32'h0B0A0908); ew(3, 32'h0F0E0D0C);
        ew(4, 32'h13121110); ew(5, 32'h17161514); ew(6, 32'h1B1A1918); ew(7, 32'h1F1E1D1C);
        cmp_writes("t6_kick", 0);
        chk("t6_kick_done", dn0, 1);

        // Reset asserted during a write cycle.
        fork
            run_frame(4, 8, 0, 0, 0);
            begin
                int k;
                for (k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (!we0) break;
                end
                chk("t6_wr_seen", k < 200, 1);
                #1 reset_n = 1'b0;
                #1;
                chk("t6_rst_we",   we0,   1);
                chk("t6_rst_addr", addr0, 0);
                qa0.delete(); qd0.delete(); dn0 = 0;
                repeat (2) @(negedge clk);
                reset_n = 1'b1;
            end
        join
        cmp_writes("t6_rst", 0);
        chk("t6_rst_done", dn0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
